// File: rtl/norm_sq_acc.sv
// norm_sq_acc: accumulates re^2 + im^2 over a VEC_LEN-element complex vector, saturating Q16.16 result.
// Optional build macro NORM_SQ_ACC_ROUND_EN: round each product half-up before the fractional shift.
module norm_sq_acc #(
    parameter int unsigned VEC_LEN   = 4,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ACC_W     = 48
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_RE,
    input  logic [31:0] IN_IM,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] DATA_OUT,
    output logic        OVF,
    output logic        BUSY
);

    localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned SUM_W = ((ACC_W > 64) ? ACC_W : 64) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_d;
    logic               ovf_d, in_ready_d, out_valid_d, busy_d;

    // Element energy: both products are squares, so they are never negative.
    logic signed [63:0] re_ext, im_ext, p_re, p_im, p_re_r, p_im_r;
    logic [63:0]        sq;
    logic [SUM_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   acc_sat;
    logic               clamp;
    logic [31:0]        data_clamped;

    assign re_ext = {{32{IN_RE[31]}}, IN_RE};
    assign im_ext = {{32{IN_IM[31]}}, IN_IM};
    assign p_re   = re_ext * re_ext;
    assign p_im   = im_ext * im_ext;

`ifdef NORM_SQ_ACC_ROUND_EN
    localparam logic signed [63:0] RND = 64'sd1 <<< (FRAC_BITS - 1);
    assign p_re_r = p_re + RND;
    assign p_im_r = p_im + RND;
`else
    assign p_re_r = p_re;
    assign p_im_r = p_im;
`endif

    assign sq           = (p_re_r >>> FRAC_BITS) + (p_im_r >>> FRAC_BITS);
    assign acc_sum      = SUM_W'(acc_q) + SUM_W'(sq);
    assign acc_sat      = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
    // ACC_W >= 33, so a saturated accumulator always exceeds the 32-bit clamp.
    assign clamp        = (acc_sat > ACC_W'(32'hFFFF_FFFF));
    assign data_clamped = clamp ? 32'hFFFF_FFFF : acc_sat[31:0];

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            DATA_OUT  <= '0;
            OVF       <= 1'b0;
            IN_READY  <= 1'b0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            DATA_OUT  <= data_d;
            OVF       <= ovf_d;
            IN_READY  <= in_ready_d;
            OUT_VALID <= out_valid_d;
            BUSY      <= busy_d;
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_d      = DATA_OUT;
        ovf_d       = OVF;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_ACC;
                    acc_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_ACC: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
                if (IN_VALID) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d     = S_HOLD;
                        data_d      = data_clamped;
                        ovf_d       = clamp;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (OUT_READY) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_norm_sq_acc.sv
// Directed and randomized bench for norm_sq_acc against an arithmetic reference model.
module tb_norm_sq_acc;

    localparam int unsigned N = 4;
    localparam longint unsigned ACC_LIMIT = (64'd1 << 48) - 64'd1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_RE;
    logic [31:0] IN_IM;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] DATA_OUT;
    logic        OVF;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    logic [31:0] vre [N];
    logic [31:0] vim [N];
    int          gap [N];

    norm_sq_acc dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_RE     (IN_RE),
        .IN_IM     (IN_IM),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DATA_OUT  (DATA_OUT),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // |x|^2 of one element with the fixed-point scaling applied.
    function automatic longint unsigned elem_energy(input logic [31:0] re, input logic [31:0] im);
        longint r, i, pr, pi;
        r  = longint'($signed(re));
        i  = longint'($signed(im));
        pr = r * r;
        pi = i * i;
`ifdef NORM_SQ_ACC_ROUND_EN
        pr = pr + 32768;
        pi = pi + 32768;
`endif
        return longint'(unsigned'(pr / 65536)) + longint'(unsigned'(pi / 65536));
    endfunction

    function automatic logic [31:0] model_sum(output logic ovf);
        longint unsigned acc = 0;
        for (int k = 0; k < N; k++) begin
            acc = acc + elem_energy(vre[k], vim[k]);
            if (acc > ACC_LIMIT) acc = ACC_LIMIT;
        end
        ovf = (acc > 64'h0000_0000_FFFF_FFFF);
        return ovf ? 32'hFFFF_FFFF : acc[31:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // One full vector: gaps before each element, hold cycles, optional stray START pulses.
    task automatic run_vector(input string tag, input int hold, input bit poke);
        logic [31:0] exp_d;
        logic        exp_o;
        exp_d = model_sum(exp_o);
        pulse_start();
        chk({tag, ":busy_start"}, 32'(BUSY), 32'd1);
        chk({tag, ":ready_acc"}, 32'(IN_READY), 32'd1);
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap[k]; g++) begin
                IN_VALID = 1'b0;
                IN_RE    = $urandom;
                IN_IM    = $urandom;
                START    = poke;
                tick();
                START    = 1'b0;
            end
            chk({tag, ":no_early_valid"}, 32'(OUT_VALID), 32'd0);
            IN_VALID = 1'b1;
            IN_RE    = vre[k];
            IN_IM    = vim[k];
            tick();
            IN_VALID = 1'b0;
        end
        chk({tag, ":out_valid"}, 32'(OUT_VALID), 32'd1);
        chk({tag, ":data"}, DATA_OUT, exp_d);
        chk({tag, ":ovf"}, 32'(OVF), 32'(exp_o));
        chk({tag, ":ready_hold"}, 32'(IN_READY), 32'd0);
        for (int h = 0; h < hold; h++) begin
            START = poke;
            tick();
            START = 1'b0;
            chk({tag, ":hold_valid"}, 32'(OUT_VALID), 32'd1);
            chk({tag, ":hold_data"}, DATA_OUT, exp_d);
        end
        OUT_READY = 1'b1;
        START     = poke;
        tick();
        OUT_READY = 1'b0;
        START     = 1'b0;
        chk({tag, ":idle_valid"}, 32'(OUT_VALID), 32'd0);
        chk({tag, ":idle_busy"}, 32'(BUSY), 32'd0);
        chk({tag, ":idle_data"}, DATA_OUT, exp_d);
        tick();
        chk({tag, ":no_restart"}, 32'(BUSY), 32'd0);
    endtask

    task automatic fill(input logic [31:0] re, input logic [31:0] im);
        for (int k = 0; k < N; k++) begin
            vre[k] = re;
            vim[k] = im;
            gap[k] = 0;
        end
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_RE = '0; IN_IM = '0;
        tick();
        chk("rst:in_ready", 32'(IN_READY), 32'd0);
        chk("rst:out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst:data", DATA_OUT, 32'd0);
        chk("rst:ovf", 32'(OVF), 32'd0);
        chk("rst:busy", 32'(BUSY), 32'd0);
        RST = 1'b1;
        tick();

        // IN_VALID in IDLE must be ignored.
        IN_VALID = 1'b1; IN_RE = 32'h0001_0000;
        tick();
        IN_VALID = 1'b0;
        chk("idle:ignore_valid", 32'(BUSY), 32'd0);

        fill(32'h0, 32'h0);
        vre[0] = 32'h0001_0000; vre[2] = 32'h0001_0000; vre[3] = 32'h0002_0000;
        vim[1] = 32'h0001_0000; vim[2] = 32'h0001_0000;
        run_vector("basic", 0, 1'b0);

        fill(32'hFFFF_0000, 32'hFFFF_0000);
        run_vector("neg", 1, 1'b0);

        fill(32'h7FFF_0000, 32'h0);
        run_vector("clamp", 2, 1'b0);

        fill(32'h0000_00B6, 32'h0);
        run_vector("round", 0, 1'b0);

        fill(32'h0001_0000, 32'h0);
        gap[1] = 2; gap[3] = 1;
        run_vector("gaps_start", 5, 1'b1);

        fill(32'h8000_0000, 32'h8000_0000);
        run_vector("sat_max", 0, 1'b0);

        // Reset mid-vector clears everything without a clock edge.
        fill(32'h0001_0000, 32'h0);
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            IN_VALID = 1'b1; IN_RE = vre[k]; IN_IM = vim[k];
            tick();
        end
        IN_VALID = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk("abort:in_ready", 32'(IN_READY), 32'd0);
        chk("abort:out_valid", 32'(OUT_VALID), 32'd0);
        chk("abort:data", DATA_OUT, 32'd0);
        chk("abort:busy", 32'(BUSY), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        run_vector("after_abort", 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) begin
                if (t % 3 == 0) begin
                    vre[k] = $urandom;
                    vim[k] = $urandom;
                end else begin
                    vre[k] = 32'($signed(17'($urandom)));
                    vim[k] = 32'($signed(17'($urandom)));
                end
                gap[k] = $urandom_range(0, 2);
            end
            run_vector("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_sq_acc.md
Name: norm_sq_acc

Overview:
- Upstream stage of the norm unit. Accumulates |x|^2 = re^2 + im^2 over a complex vector of VEC_LEN elements.
- Presents the sum as a 32-bit unsigned Q16.16 word on DATA_OUT. This word feeds the square-root stage's DATA_IN.
- A simple valid/ready pair lets the precoder datapath stream elements in and hold the result until the sqrt stage takes it.

Parameters:
- VEC_LEN, 4, elements per vector; legal range 1..256.
- FRAC_BITS, 16, fractional bits of the input and output fixed-point format.
- ACC_W, 48, internal accumulator width in bits; must be at least 33.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle pulse that begins a new vector; honoured only in IDLE.
- IN_VALID  in  1  IN_RE/IN_IM carry a valid element.
- IN_READY  out  1  block accepts an element this cycle.
- IN_RE  in  32  real part, signed two's complement Q16.16.
- IN_IM  in  32  imaginary part, signed two's complement Q16.16.
- OUT_VALID  out  1  DATA_OUT holds the completed sum.
- OUT_READY  in  1  downstream consumes DATA_OUT.
- DATA_OUT  out  32  sum of squares, unsigned Q16.16, saturated.
- OVF  out  1  the sum for the current result saturated.
- BUSY  out  1  high in ACC and HOLD.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, accumulator=0, element count=0, IN_READY=0, OUT_VALID=0, DATA_OUT=0, OVF=0, BUSY=0.
- States: IDLE, ACC, HOLD. Encoding is free; illegal states return to IDLE on the next edge.
- IDLE:
  - IN_READY=0; IN_VALID is ignored.
  - START=1 -> ACC; accumulator, count and OVF are cleared on the same edge.
  - DATA_OUT keeps the last result.
- ACC:
  - IN_READY=1. An element is accepted on an edge where IN_VALID=1.
  - Per element: sq = ((IN_RE*IN_RE) >>> FRAC_BITS) + ((IN_IM*IN_IM) >>> FRAC_BITS).
  - Each product is a signed 64-bit result and is always non-negative. Shifts truncate toward zero.
  - sq is zero-extended into the accumulator; the accumulator saturates at 2^ACC_W-1 and never wraps.
  - Count increments per accepted element. Accepting element VEC_LEN-1 -> HOLD on the same edge.
  - On that edge: DATA_OUT = min(final accumulator, 0xFFFFFFFF); OVF=1 if the clamp was applied or the accumulator saturated.
  - START is ignored in ACC.
- HOLD:
  - OUT_VALID=1, IN_READY=0, DATA_OUT stable.
  - OUT_READY=1 -> IDLE with OUT_VALID=0 next cycle.
  - START is ignored in HOLD, including when it coincides with OUT_READY.
- Latency:
  - OUT_VALID rises on the edge that accepts the last element, i.e. 0 extra cycles.
  - Minimum vector time is VEC_LEN+1 cycles (START edge plus VEC_LEN accepts).
- VEC_LEN=1: one accept moves ACC directly to HOLD.
- IN_VALID gaps in ACC stall the block without side effects; there is no timeout.
- RST asserted mid-vector aborts the vector; no partial result is ever presented.
- BUSY = (state != IDLE).

Optional Feature:
- Macro: NORM_SQ_ACC_ROUND_EN.
- Defined: each product is rounded half-up before the shift, i.e. 2^(FRAC_BITS-1) is added before >>> FRAC_BITS.
- Undefined: truncation as described under Behaviour.
- The macro affects no other behaviour.

Test Plan:
- Reset then START; elements (1.0,0),(0,1.0),(1.0,1.0),(2.0,0), i.e. 0x00010000 / 0x00020000 / 0, IN_VALID held high.
  -> OUT_VALID on the 4th accept edge, DATA_OUT=0x00080000, OVF=0; OUT_READY pulse returns to IDLE.
- Negative inputs (-1.0,-1.0) = 0xFFFF0000 x2 for all 4 elements -> DATA_OUT=0x00080000.
- Element re=0x7FFF0000, im=0 four times -> DATA_OUT=0xFFFFFFFF, OVF=1.
- Re=0x000000B6, im=0, 4 elements -> DATA_OUT=0x00000000 without the macro; 0x00000004 with NORM_SQ_ACC_ROUND_EN.
- IN_VALID toggled 1-0-0-1-1-0-1 with elements of 1.0, and START pulsed during ACC and during HOLD -> DATA_OUT=0x00040000, no restart.
  - Hold OUT_READY=0 for 5 cycles -> OUT_VALID and DATA_OUT stable throughout.
- RST asserted after 2 accepts -> all outputs return to reset values immediately (asynchronous).
  - New START with 4x(1.0,0) -> 0x00040000.
